// File: rtl/user_insn_coproc_if.sv
// User-instruction bus between the CPU (master) and the coprocessor (slave).
interface user_insn_coproc_if;
    logic [10:0] user_opcode;
    logic [31:0] user_operand_0;
    logic [31:0] user_operand_1;
    logic        user_valid;
    logic [31:0] user_result;
    logic        user_complete;
    logic        busy;

    modport master (
        output user_opcode, user_operand_0, user_operand_1, user_valid,
        input  user_result, user_complete, busy
    );

    modport slave (
        input  user_opcode, user_operand_0, user_operand_1, user_valid,
        output user_result, user_complete, busy
    );
endinterface

// File: rtl/user_insn_coproc.sv
// User-instruction coprocessor: single-cycle ALU ops plus an iterative
// shift-add multiplier and a reflected CRC-32 engine.
module user_insn_coproc #(
    parameter int CRC_BITS_PER_CYCLE = 8,
    parameter bit MUL_ENABLE         = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    user_insn_coproc_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_t;

    localparam int          CRC_CYCLES = 32 / CRC_BITS_PER_CYCLE;
    localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
    localparam logic [3:0]  OP_MULHI   = 4'h2;
    localparam logic [3:0]  OP_CRC     = 4'h3;
    localparam logic [3:0]  OP_ILLEGAL = 4'hF;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    logic [3:0]  in_nib;
    logic        in_illegal;
    logic        in_is_mul;
    logic        in_is_crc;
    logic [31:0] alu_res;
    logic [5:0]  pop_cnt;
    logic [31:0] rot_res;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [31:0] crc_next;

    // Decode the incoming request; only meaningful while IDLE.
    always_comb begin
        in_nib     = bus.user_opcode[3:0];
        in_illegal = (|bus.user_opcode[10:4]) ||
                     (!MUL_ENABLE && (in_nib == 4'h1 || in_nib == 4'h2));
        in_is_mul  = !in_illegal && (in_nib == 4'h1 || in_nib == 4'h2);
        in_is_crc  = !in_illegal && (in_nib == OP_CRC);
    end

    // Single-cycle results computed straight from the operands being captured.
    always_comb begin
        alu_res = '0;
        pop_cnt = '0;
        for (int i = 0; i < 32; i++) begin
            pop_cnt = pop_cnt + 6'(bus.user_operand_0[i]);
        end
        // A shift of 32 yields 0, so rotate-by-0 returns A unchanged.
        rot_res = (bus.user_operand_0 << bus.user_operand_1[4:0]) |
                  (bus.user_operand_0 >> (6'd32 - {1'b0, bus.user_operand_1[4:0]}));
        if (!in_illegal) begin
            case (in_nib)
                4'h0:    alu_res = bus.user_operand_0 + bus.user_operand_1;
                4'h4:    alu_res = {26'd0, pop_cnt};
                4'h5:    alu_res = rot_res;
                default: alu_res = '0;
            endcase
        end
    end

    // One radix-2 multiply step: {hi,lo} with the multiplier held in lo.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
    end

    // CRC_BITS_PER_CYCLE reflected CRC steps; data bits taken from b_q LSB first.
    always_comb begin
        crc_next = acc_q[31:0];
        for (int k = 0; k < CRC_BITS_PER_CYCLE; k++) begin
            if (crc_next[0] ^ b_q[k]) begin
                crc_next = (crc_next >> 1) ^ CRC_POLY;
            end else begin
                crc_next = crc_next >> 1;
            end
        end
    end

    // Next-state and datapath update for the request/iterate/complete FSM.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.user_valid) begin
                    op_d = in_illegal ? OP_ILLEGAL : in_nib;
                    a_d  = bus.user_operand_0;
                    b_d  = bus.user_operand_1;
                    if (in_is_mul) begin
                        acc_d   = {32'd0, bus.user_operand_1};
                        cnt_d   = 5'd31;
                        state_d = BUSY;
                    end else if (in_is_crc) begin
                        acc_d   = {32'd0, bus.user_operand_0};
                        cnt_d   = 5'(CRC_CYCLES - 1);
                        state_d = BUSY;
                    end else begin
                        result_d = alu_res;
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 5'd1;
                if (op_q == OP_CRC) begin
                    acc_d = {32'd0, crc_next};
                    b_d   = b_q >> CRC_BITS_PER_CYCLE;
                    if (cnt_q == 5'd0) result_d = crc_next;
                end else begin
                    acc_d = mul_next;
                    if (cnt_q == 5'd0) begin
                        result_d = (op_q == OP_MULHI) ? mul_next[63:32] : mul_next[31:0];
                    end
                end
                if (cnt_q == 5'd0) state_d = DONE;
            end
            // A still-high valid parks in HOLD so it cannot start a new op.
            DONE:    state_d = bus.user_valid ? HOLD : IDLE;
            HOLD:    if (!bus.user_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.user_result   = result_q;
    assign bus.user_complete = (state_q == DONE);
    assign bus.busy          = (state_q == BUSY);
endmodule
